// File: rtl/spi_transmitter_synchronous.sv
// SPI slave transmitter running entirely on the system clock. ss/sclk are oversampled
// and edge-detected; a holding register lets the host queue the next word mid-transfer.
module spi_transmitter_synchronous #(
    parameter int bitcount      = 16,
    parameter int ss_polarity   = 0,
    parameter int sclk_polarity = 1,
    parameter int sclk_phase    = 1,
    parameter int msb_first     = 1,
    parameter int sync_stages   = 2,
    parameter int idle_sdo      = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ss,
    input  logic                sclk,
    output logic                sdo,
    input  logic [bitcount-1:0] data,
    input  logic                load,
    output logic                ready,
    output logic                complete,
    output logic                aborted,
    output logic                underrun
);

    localparam int   CW       = $clog2(bitcount + 1);
    localparam int   WW       = $clog2(sync_stages + 2);
    localparam logic SS_IDLE  = (ss_polarity == 0);
    localparam logic CPOL     = (sclk_polarity != 0);
    localparam logic CPHA     = (sclk_phase != 0);
    localparam logic IDLE_SDO = (idle_sdo != 0);
    localparam logic [WW-1:0] WAIT_MAX = WW'(sync_stages + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(bitcount - 1);
    localparam logic [CW-1:0] ALL_BITS = CW'(bitcount);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic [sync_stages-1:0] ss_sync, sclk_sync;
    logic                  ss_hist, sclk_hist;
    logic                  load_q;
    logic [bitcount-1:0]   hold, sreg, next_word;
    logic [CW-1:0]         ncnt, scnt;
    logic [WW-1:0]         wcnt;

    logic ss_on, ss_was, ss_rise;
    logic sclk_now, sclk_lead, sclk_trail, drive_edge, sample_edge;
    logic load_edge;

    always_ff @(posedge clock) begin
        if (reset) begin
            ss_sync   <= {sync_stages{SS_IDLE}};
            sclk_sync <= {sync_stages{CPOL}};
            ss_hist   <= SS_IDLE;
            sclk_hist <= CPOL;
        end else begin
            ss_sync   <= {ss_sync[sync_stages-2:0], ss};
            sclk_sync <= {sclk_sync[sync_stages-2:0], sclk};
            ss_hist   <= ss_sync[sync_stages-1];
            sclk_hist <= sclk_sync[sync_stages-1];
        end
    end

    assign ss_on       = (ss_sync[sync_stages-1] != SS_IDLE);
    assign ss_was      = (ss_hist != SS_IDLE);
    assign ss_rise     = ss_on & ~ss_was;
    assign sclk_now    = sclk_sync[sync_stages-1];
    assign sclk_lead   = (sclk_hist == CPOL) && (sclk_now != CPOL);
    assign sclk_trail  = (sclk_hist != CPOL) && (sclk_now == CPOL);
    assign drive_edge  = CPHA ? sclk_lead : sclk_trail;
    assign sample_edge = CPHA ? sclk_trail : sclk_lead;
    assign load_edge   = load & ~load_q;

    // n-th bit on the wire, honouring transmit order
    function automatic logic bit_at(input logic [bitcount-1:0] w, input logic [CW-1:0] n);
        logic [CW-1:0]       i;
        logic [bitcount-1:0] t;
        i = (msb_first != 0) ? (LAST_BIT - n) : n;
        t = w >> i;
        return t[0];
    endfunction

    // A load coinciding with ss assertion bypasses the holding register
    always_comb begin
        next_word = sreg;
        if (load_edge)   next_word = data;
        else if (!ready) next_word = hold;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= WAIT_IDLE;
            hold     <= '0;
            sreg     <= '0;
            ready    <= 1'b1;
            sdo      <= IDLE_SDO;
            complete <= 1'b0;
            aborted  <= 1'b0;
            underrun <= 1'b0;
            load_q   <= 1'b0;
            ncnt     <= '0;
            scnt     <= '0;
            wcnt     <= '0;
        end else begin
            complete <= 1'b0;
            aborted  <= 1'b0;
            underrun <= 1'b0;
            load_q   <= load;
            if (load_edge) begin
                hold  <= data;
                ready <= 1'b0;
            end
            case (state)
                WAIT_IDLE: begin
                    // let the synchronisers fill with real pin levels before trusting them
                    if (wcnt != WAIT_MAX) wcnt  <= wcnt + 1'b1;
                    else if (!ss_on)      state <= IDLE;
                end
                IDLE: begin
                    sdo <= IDLE_SDO;
                    if (ss_rise) begin
                        state    <= SHIFT;
                        sreg     <= next_word;
                        ready    <= 1'b1;
                        underrun <= ~load_edge & ready;
                        scnt     <= '0;
                        if (!CPHA) begin
                            sdo  <= bit_at(next_word, '0);
                            ncnt <= CW'(1);
                        end else begin
                            ncnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (!ss_on) begin
                        aborted <= 1'b1;
                        sdo     <= IDLE_SDO;
                        state   <= IDLE;
                    end else begin
                        if (drive_edge && ncnt != ALL_BITS) begin
                            sdo  <= bit_at(sreg, ncnt);
                            ncnt <= ncnt + 1'b1;
                        end
                        if (sample_edge) begin
                            scnt <= scnt + 1'b1;
                            if (scnt == LAST_BIT) begin
                                complete <= 1'b1;
                                state    <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!ss_on) begin
                        sdo   <= IDLE_SDO;
                        state <= IDLE;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transmitter_synchronous.sv
// Drives two instances (mode 3 MSB-first 16-bit, mode 0 LSB-first 8-bit) from one SPI
// master and checks the wire bits and pulses against a word-level queueing model.
module tb_spi_transmitter_synchronous;

    localparam int P = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ss    = 1'b0;
    logic        ph    = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] data  = '0;
    logic        sclk_a, sclk_b;
    logic        sdo_a, ready_a, cmp_a, abt_a, und_a;
    logic        sdo_b, ready_b, cmp_b, abt_b, und_b;

    assign sclk_a = ~ph;
    assign sclk_b = ph;

    always #5 clock = ~clock;

    spi_transmitter_synchronous dut_a (
        .clock(clock), .reset(reset), .ss(ss), .sclk(sclk_a), .sdo(sdo_a),
        .data(data), .load(load), .ready(ready_a),
        .complete(cmp_a), .aborted(abt_a), .underrun(und_a)
    );

    spi_transmitter_synchronous #(
        .bitcount(8), .sclk_polarity(0), .sclk_phase(0), .msb_first(0)
    ) dut_b (
        .clock(clock), .reset(reset), .ss(ss), .sclk(sclk_b), .sdo(sdo_b),
        .data(data[7:0]), .load(load), .ready(ready_b),
        .complete(cmp_b), .aborted(abt_b), .underrun(und_b)
    );

    int n_cmp_a = 0, n_abt_a = 0, n_und_a = 0;
    int n_cmp_b = 0, n_abt_b = 0, n_und_b = 0;

    always @(posedge clock) begin
        n_cmp_a <= n_cmp_a + int'(cmp_a);
        n_abt_a <= n_abt_a + int'(abt_a);
        n_und_a <= n_und_a + int'(und_a);
        n_cmp_b <= n_cmp_b + int'(cmp_b);
        n_abt_b <= n_abt_b + int'(abt_b);
        n_und_b <= n_und_b + int'(und_b);
    end

    int total = 0, bad = 0;

    // word-level model: what the slave should send next
    logic [15:0] m_hold = '0;
    logic [15:0] m_last = '0;
    bit          m_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d);
        data = d;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        m_hold = d;
        m_pend = 1'b1;
        chk("ready_a_after_load", ready_a, 0);
        chk("ready_b_after_load", ready_b, 0);
    endtask

    task automatic transfer(input int k, input bit sim_load, input logic [15:0] sim_data);
        int ca0, cb0, aa0, ab0, ua0, ub0, na, nb;
        logic [15:0] exp_word, rxa, ma;
        logic [7:0]  rxb, mb;
        logic [15:0] ones16;
        logic [7:0]  ones8;
        bit          exp_und;
        ones16 = 16'hFFFF;
        ones8  = 8'hFF;
        rxa = '0;
        rxb = '0;
        ca0 = n_cmp_a; cb0 = n_cmp_b; aa0 = n_abt_a;
        ab0 = n_abt_b; ua0 = n_und_a; ub0 = n_und_b;
        if (sim_load) begin
            exp_word = sim_data; exp_und = 1'b0; m_pend = 1'b0;
        end else if (m_pend) begin
            exp_word = m_hold; exp_und = 1'b0; m_pend = 1'b0;
        end else begin
            exp_word = m_last; exp_und = 1'b1;
        end
        m_last = exp_word;

        ss = 1'b0;
        if (sim_load) begin
            tick(2);
            data = sim_data;
            load = 1'b1;
            tick(1);
            load = 1'b0;
            tick(5);
        end else begin
            tick(8);
        end
        chk("ready_a_at_start", ready_a, 1);
        chk("ready_b_at_start", ready_b, 1);
        chk("underrun_a", n_und_a - ua0, exp_und);
        chk("underrun_b", n_und_b - ub0, exp_und);

        for (int i = 0; i < k; i++) begin
            if (i < 8) rxb[i] = sdo_b;
            ph = 1'b1;
            tick(P);
            rxa[15-i] = sdo_a;
            ph = 1'b0;
            tick(P);
            chk("complete_a_progress", n_cmp_a - ca0, (i + 1 >= 16));
            chk("complete_b_progress", n_cmp_b - cb0, (i + 1 >= 8));
        end

        na = k;
        nb = (k < 8) ? k : 8;
        ma = ~(ones16 >> na);
        mb = ~(ones8 << nb);
        chk("rx_word_a", rxa & ma, exp_word & ma);
        chk("rx_word_b", rxb & mb, exp_word[7:0] & mb);

        ss = 1'b1;
        tick(8);
        chk("aborted_a", n_abt_a - aa0, (k < 16));
        chk("aborted_b", n_abt_b - ab0, (k < 8));
        chk("sdo_a_idle", sdo_a, 0);
        chk("sdo_b_idle", sdo_b, 0);
    endtask

    initial begin
        // reset with ss asserted and sclk toggling
        tick(1);
        chk("reset_ready_a", ready_a, 1);
        chk("reset_ready_b", ready_b, 1);
        chk("reset_sdo_a", sdo_a, 0);
        chk("reset_sdo_b", sdo_b, 0);
        chk("reset_pulses", {cmp_a, abt_a, und_a, cmp_b, abt_b, und_b}, 0);
        for (int i = 0; i < 4; i++) begin
            ph = ~ph;
            tick(3);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ph = ~ph;
            tick(P);
        end
        chk("held_ss_pulses", n_cmp_a + n_abt_a + n_und_a + n_cmp_b + n_abt_b + n_und_b, 0);
        chk("held_ss_sdo_a", sdo_a, 0);
        chk("held_ss_sdo_b", sdo_b, 0);
        chk("held_ss_ready", {ready_a, ready_b}, 2'b11);
        ss = 1'b1;
        tick(8);

        // first transfer after reset: nothing loaded, reset word re-sent
        transfer(16, 1'b0, '0);

        do_load(16'hA55A);
        transfer(16, 1'b0, '0);

        do_load(16'h0001);
        transfer(16, 1'b0, '0);

        do_load(16'h1234);
        transfer(16, 1'b0, '0);
        transfer(16, 1'b0, '0);

        do_load(16'h5678);
        transfer(5, 1'b0, '0);
        do_load(16'hBEEF);
        transfer(16, 1'b0, '0);

        do_load(16'h1111);
        do_load(16'h2222);
        transfer(16, 1'b0, '0);

        transfer(16, 1'b1, 16'h3333);

        for (int r = 0; r < 12; r++) begin
            int kind, k;
            kind = $urandom_range(0, 3);
            if (kind == 1 || kind == 3) do_load(16'($urandom));
            if (kind == 2) begin
                do_load(16'($urandom));
                do_load(16'($urandom));
            end
            k = ($urandom_range(0, 1) == 0) ? 16 : $urandom_range(1, 16);
            if (!m_pend && $urandom_range(0, 3) == 0)
                transfer(k, 1'b1, 16'($urandom));
            else
                transfer(k, 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_transmitter_synchronous.md
Name: spi_transmitter_synchronous

Overview:
- Next-generation SPI slave transmitter. Fully synchronous to the system `clock`: externally generated `ss`/`sclk` are oversampled through synchronisers and edge-detected, with no clocking from `sclk`.
- Supports all four CPOL/CPHA modes and MSB/LSB-first order.
- A double-buffered load handshake lets the host queue the next word during a transfer.
- Reports completion, abort and underrun as single-cycle pulses. Sits between a host data source and the SPI pins in slave designs.

Parameters:
- bitcount, 16, word length in bits; legal range ≥ 2.
- ss_polarity, 0, 0 = `ss` active low, 1 = active high.
- sclk_polarity, 1, CPOL: idle level of `sclk`.
- sclk_phase, 1, CPHA: 0 = first bit driven on `ss` assertion, 1 = first bit driven on first `sclk` edge.
- msb_first, 1, 1 = MSB transmitted first, 0 = LSB first.
- sync_stages, 2, synchroniser depth for `ss` and `sclk` (≥ 2).
- idle_sdo, 0, `sdo` level while not transmitting.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ss  input  1  slave select (asynchronous to `clock`).
- sclk  input  1  serial clock (asynchronous to `clock`).
- sdo  output  1  serial data out (registered).
- data  input  bitcount  word to transmit.
- load  input  1  rising edge captures `data` into the holding register.
- ready  output  1  high when the holding register is empty.
- complete  output  1  one-cycle pulse: last bit sampled.
- aborted  output  1  one-cycle pulse: `ss` released before completion.
- underrun  output  1  one-cycle pulse: transfer started with an empty holding register.

Behaviour:
- Reset values:
  - `sdo` = idle_sdo; `ready` = 1; `complete`, `aborted`, `underrun` = 0.
  - Holding and shift registers = 0; bit counter = 0; state WAIT_IDLE.
  - Synchroniser flops load inactive levels (ss inactive, sclk = sclk_polarity).
- Synchronisers: `ss` and `sclk` each pass sync_stages flops, plus one history flop for edge detection.
  - leading edge = transition away from idle level; trailing edge = transition back to it.
  - Pin-to-internal-event latency is sync_stages+1 clocks. `sdo` changes one clock after the internal event.
  - Requirement: each `sclk` phase ≥ sync_stages+2 `clock` periods.
- Load: `load` rising edge (previous-cycle compare) copies `data` into the holding register and sets pending (`ready` = 0).
  - A load while pending overwrites the holding register (latest wins).
- States:
  - WAIT_IDLE: entered from reset; ignore everything until synchronised `ss` is inactive, then go to IDLE. A transfer never starts with `ss` already asserted at reset release.
  - IDLE: `sdo` = idle_sdo.
    - On a synchronised `ss` assertion edge, go to SHIFT.
    - If pending: holding → shift register, pending cleared, `ready` = 1.
    - Else: shift register keeps its previous word (re-sent) and `underrun` pulses.
    - Load edge in the same cycle as `ss` assertion: new `data` goes straight to the shift register, pending stays 0, no underrun.
  - SHIFT:
    - Bit index starts at bitcount-1 (msb_first) or 0 and steps by ±1.
    - CPHA=0: the first bit is driven on the cycle after entry. Each subsequent bit is driven on a trailing edge. Leading edges are the sampling edges.
    - CPHA=1: each bit is driven on a leading edge. Trailing edges are the sampling edges.
    - Count sampling edges. On the bitcount-th one, pulse `complete` and go to DONE.
    - `ss` deassertion in SHIFT: pulse `aborted` (no `complete`), `sdo` = idle_sdo, go to IDLE; the shifted word is not requeued.
  - DONE: `sdo` holds the last bit. Further `sclk` edges are ignored. `ss` deassertion → IDLE, with no pulse.
- Load during SHIFT/DONE: affects only the holding register.
- Reset mid-transfer: immediate return to reset values, no pulses, next state WAIT_IDLE.
- Only `ss` and `sclk` cross the clock domain; `data`/`load` are synchronous to `clock`.

Test Plan:
- Mode 3 (CPOL=1, CPHA=1), MSB first, bitcount=16: load 0xA55A, assert ss, 16 sclk cycles with 8-clock phases → master samples 1010010101011010 on rising edges; `complete` pulses once after the 16th rising edge; `ready` goes 1 at ss assertion.
- Mode 0 (CPOL=0, CPHA=0), LSB first, bitcount=8: load 0x01 → bit0 = 1 valid before the first rising sclk; remaining bits 0; `complete` pulses on the 8th rising edge.
- Underrun: two transfers with a single load of 0x1234 → second transfer re-sends 0x1234 and `underrun` pulses once at its start.
- Abort: release ss after 5 of 16 bits → `aborted` pulses, `sdo` = idle_sdo, no `complete`. The next transfer with a new load of 0xBEEF sends 0xBEEF.
- Overwrite and simultaneity:
  - Load 0x1111 then 0x2222 before ss → 0x2222 sent.
  - Load 0x3333 in the same cycle ss assertion is detected → 0x3333 sent, no underrun, `ready` stays 1.
- Reset with ss held asserted and sclk toggling → `sdo` = idle_sdo, no pulses, no shifting until ss is deasserted and then reasserted.
